// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - mips_wb_pkg: result-select, load-type and state encodings for wb_stage
package mips_wb_pkg;

    // Result source selected by the MEM stage; code 3 falls back to ALU.
    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_LINK = 2'd2
    } sel_e;

    // Load width/extension; unlisted codes fall back to a full word.
    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_H  = 3'd1,
        LD_HU = 3'd2,
        LD_B  = 3'd3,
        LD_BU = 3'd4
    } ld_type_e;

    // IDLE accepts; WAIT owes a load response; DRAIN swallows a flushed load's response.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM-to-writeback instruction handshake and memory response bundle
interface wb_stage_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic          in_wen;
    logic [AW-1:0] in_rd;
    logic [1:0]    in_sel;
    logic [2:0]    in_ld_type;
    logic [1:0]    in_addr_lo;
    logic [DW-1:0] in_alu;
    logic [DW-1:0] in_pc;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    modport master (
        output in_valid, in_wen, in_rd, in_sel, in_ld_type, in_addr_lo,
               in_alu, in_pc, mem_rvalid, mem_rdata,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_wen, in_rd, in_sel, in_ld_type, in_addr_lo,
               in_alu, in_pc, mem_rvalid, mem_rdata,
        output in_ready
    );
endinterface

// File: rtl/wb_stage_load_align.sv
// rtl/wb_stage_load_align.sv - load_align: little-endian byte/halfword select with sign/zero extension
module load_align
    import mips_wb_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rdata,
    input  logic [2:0]    ld_type,
    input  logic [1:0]    addr_lo,
    output logic [DW-1:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // addr_lo[0] is deliberately ignored for halfwords: misaligned halves are not trapped here.
    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

    // Extend the selected lane according to the load type.
    always_comb begin
        data = rdata;
        case (ld_type)
            LD_H:    data = {{(DW-16){half_sel[15]}}, half_sel};
            LD_HU:   data = {{(DW-16){1'b0}}, half_sel};
            LD_B:    data = {{(DW-8){byte_sel[7]}}, byte_sel};
            LD_BU:   data = {{(DW-8){1'b0}}, byte_sel};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MIPS writeback stage; optional register-file bypass under WB_BYPASS_EN
module wb_stage
    import mips_wb_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_stage_if.slave     up,
    input  logic          flush,
    output logic [AW-1:0] wb_num,
    output logic [DW-1:0] wb_data,
    output logic          wb_we,
    output logic          busy
`ifdef WB_BYPASS_EN
    ,
    input  logic [AW-1:0] rs_num,
    input  logic [AW-1:0] rt_num,
    input  logic [DW-1:0] rs_rdata,
    input  logic [DW-1:0] rt_rdata,
    output logic [DW-1:0] rs_fwd,
    output logic [DW-1:0] rt_fwd
`endif
);
    state_e        state_q, state_d;
    logic [AW-1:0] p_rd;
    logic          p_wen;
    logic [2:0]    p_ld_type;
    logic [1:0]    p_addr_lo;

    logic          accept;
    logic          capture;
    logic          commit;
    logic [AW-1:0] c_rd;
    logic          c_wen;
    logic [DW-1:0] c_data;
    logic [2:0]    al_type;
    logic [1:0]    al_lo;
    logic [DW-1:0] al_data;

    assign up.in_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign accept      = up.in_valid & up.in_ready & ~flush;

    // In IDLE a same-cycle response aligns with the offered load; otherwise use the captured one.
    assign al_type = (state_q == ST_IDLE) ? up.in_ld_type : p_ld_type;
    assign al_lo   = (state_q == ST_IDLE) ? up.in_addr_lo : p_addr_lo;

    load_align #(.DW(DW)) u_align (
        .rdata   (up.mem_rdata),
        .ld_type (al_type),
        .addr_lo (al_lo),
        .data    (al_data)
    );

    // Next state, commit decision and the result to be written.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        commit  = 1'b0;
        c_rd    = up.in_rd;
        c_wen   = up.in_wen;
        c_data  = up.in_alu;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (up.in_sel)
                        SEL_LOAD: begin
                            if (up.mem_rvalid) begin
                                commit = 1'b1;
                                c_data = al_data;
                            end else begin
                                capture = 1'b1;
                                state_d = ST_WAIT;
                            end
                        end
                        SEL_LINK: begin
                            commit = 1'b1;
                            c_data = up.in_pc + DW'(8);
                        end
                        default: commit = 1'b1;
                    endcase
                end
            end
            ST_WAIT: begin
                c_rd   = p_rd;
                c_wen  = p_wen;
                c_data = al_data;
                if (flush) begin
                    state_d = up.mem_rvalid ? ST_IDLE : ST_DRAIN;
                end else if (up.mem_rvalid) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (up.mem_rvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register plus the fields of a load left waiting for its response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            p_rd      <= '0;
            p_wen     <= 1'b0;
            p_ld_type <= '0;
            p_addr_lo <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                p_rd      <= up.in_rd;
                p_wen     <= up.in_wen;
                p_ld_type <= up.in_ld_type;
                p_addr_lo <= up.in_addr_lo;
            end
        end
    end

    // Registered register-file write port; r0 still updates num/data but never asserts we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we   <= 1'b0;
            wb_num  <= '0;
            wb_data <= '0;
        end else begin
            wb_we <= commit & c_wen & (c_rd != '0);
            if (commit) begin
                wb_num  <= c_rd;
                wb_data <= c_data;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign rs_fwd = (wb_we && (wb_num == rs_num)) ? wb_data : rs_rdata;
    assign rt_fwd = (wb_we && (wb_num == rt_num)) ? wb_data : rt_rdata;
`endif
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the MIPS pipeline, sitting directly upstream of the register file. Takes one retiring instruction per handshake from the MEM stage and selects the result source: ALU, load data, or link address. Aligns and sign/zero-extends load data, waiting for late memory responses when needed. Drives the register-file write port (write number, write data, write enable) from registered outputs.

## Interface
- `DW`, 32: datapath width.
- `AW`, 5: register-number width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  MEM stage offers an instruction.
- `in_ready`  out  1  stage accepts this cycle; accept = `in_valid & in_ready & ~flush`.
- `in_wen`  in  1  instruction writes a register.
- `in_rd`  in  AW  destination register number.
- `in_sel`  in  2  result source: 0 ALU, 1 load, 2 link; 3 is treated as ALU.
- `in_ld_type`  in  3  load type: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; others are treated as LW.
- `in_addr_lo`  in  2  low bits of the load address.
- `in_alu`  in  DW  ALU result.
- `in_pc`  in  DW  instruction PC.
- `mem_rvalid`  in  1  load data is valid this cycle; responses arrive in order.
- `mem_rdata`  in  DW  raw word read from memory.
- `flush`  in  1  kills the pending and offered instruction.
- `wb_num`  out  AW  register-file write number.
- `wb_data`  out  DW  register-file write data.
- `wb_we`  out  1  register-file write enable; high for exactly one cycle per commit.
- `busy`  out  1  high in WAIT or DRAIN.

## Operation
- **States:** IDLE, WAIT (load outstanding), DRAIN (response of a flushed load still owed).
- **IDLE:**
  - `in_ready`=1.
  - On accept of a non-load, or of a load with `mem_rvalid` in the same cycle: compute the result and commit next cycle. Stay in IDLE.
  - On accept of a load without `mem_rvalid`: capture rd, wen, ld_type and addr_lo, then go to WAIT.
- **WAIT:**
  - `in_ready`=0.
  - `mem_rvalid` without flush: commit the aligned data next cycle, then go to IDLE.
  - flush without `mem_rvalid`: go to DRAIN.
  - flush with `mem_rvalid`: discard the data, go to IDLE.
- **DRAIN:** `in_ready`=0. `mem_rvalid` is discarded and the state returns to IDLE. flush has no further effect.
- **`mem_rvalid` outside WAIT, DRAIN or a same-cycle load accept:** ignored.
- **Commit:**
  - `wb_we`<=wen & (rd≠0).
  - `wb_num`<=rd.
  - `wb_data`<=result.
  - Register 0 is never written, but `wb_data`/`wb_num` still update.
- **Result:**
  - ALU: `in_alu`.
  - Link: `in_pc`+8, modulo 2^DW.
  - Load: aligned word, little-endian.
- **Load alignment:**
  - LB/LBU: byte `addr_lo`.
  - LH/LHU: halfword `addr_lo[1]`; `addr_lo[0]` is ignored (no misalign trap).
  - LW: ignores `addr_lo`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- **flush vs. committed write:** flush never cancels a `wb_we` already registered.

## Timing
- Reset values:
  - state IDLE.
  - `wb_we`=0, `wb_num`=0, `wb_data`=0, `busy`=0.
  - `in_ready`=1 once reset is released.
- Non-load accepted at cycle N: `wb_we` is high in cycle N+1. Back-to-back accepts give `wb_we` on consecutive cycles.
- Load accepted at N with response at M≥N: `wb_we` is high in cycle M+1.
- `in_ready` and `busy` are combinational from state only. They do not depend on `in_valid`.
- Reset asserted mid-operation abandons any pending load immediately. A later stale `mem_rvalid` seen in IDLE is ignored.

## Configuration
- Macro `WB_BYPASS_EN`.
- When defined, add these ports:
  - `rs_num`/`rt_num` in AW.
  - `rs_rdata`/`rt_rdata` in DW.
  - `rs_fwd`/`rt_fwd` out DW.
- Forward rule: `rs_fwd` = (`wb_we` & `wb_num`==`rs_num`) ? `wb_data` : `rs_rdata`, and likewise for rt. This is combinational and covers same-cycle write/read of the register file.
- When undefined, these ports and the bypass logic are absent. Behaviour is otherwise identical.

## Structure
- Package `mips_wb_pkg` holds:
  - result-select encodings (SEL_ALU, SEL_LOAD, SEL_LINK).
  - load-type encodings (LD_W, LD_H, LD_HU, LD_B, LD_BU).
  - state encodings (ST_IDLE, ST_WAIT, ST_DRAIN).
- One sub-module, `load_align`, is purely combinational. It maps (`mem_rdata`, ld_type, addr_lo) to the extended word and is instantiated once.

## Test plan
- ALU op with rd=5, `in_alu`=0x1234_5678, accepted at N -> `wb_we`=1, `wb_num`=5, `wb_data`=0x1234_5678 at N+1 only.
- LB with rd=8, addr_lo=3, `mem_rdata`=0x80FF_FFFF, same-cycle rvalid -> `wb_data`=0xFFFF_FF80. LBU with the same inputs -> 0x0000_0080. LH with addr_lo=2 -> 0xFFFF_80FF.
- LW accepted at N, `mem_rvalid` at N+3 -> `in_ready`=0 and `busy`=1 during N+1..N+3, `wb_we` at N+4, `in_ready`=1 at N+4.
- Load pending, flush at N+1, rvalid at N+4 -> DRAIN, no `wb_we` ever, IDLE at N+5. Flush coincident with rvalid -> IDLE at N+2, no `wb_we`.
- Link op with rd=31, `in_pc`=0x0040_0010 -> `wb_data`=0x0040_0018. Same op with rd=0 -> `wb_we` stays 0.
- With `WB_BYPASS_EN`: commit to rd=9 with `rs_num`=9 -> `rs_fwd`=`wb_data`. With `rs_num`=10 -> `rs_fwd`=`rs_rdata`.
